// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared state encoding and default configuration for the sweep controller
//
// Purpose : FSM state type used by sweep_ctrl and default WIDTH / NPASS / PCW
//           values picked up by the interface and the top-level parameters.
// Ports   : none (package).
package sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_UP   = 2'd2,
      ST_DOWN = 2'd3
   } sweep_state_e;

   localparam int SWEEP_WIDTH_DEF = 4;
   localparam int SWEEP_NPASS_DEF = 2;
   localparam int SWEEP_PCW_DEF   = 8;

endpackage

// File: rtl/sweep_ctrl_if.sv
// rtl/sweep_ctrl_if.sv - request/status bundle between a sweep client and sweep_ctrl
//
// Purpose : groups the sweep request (start/stop/bounds) and the sweep status
//           (count/dir/busy/done/err) so they travel as one port.
// Signals : master drives start, stop, lo[WIDTH], hi[WIDTH] (and pause when
//           SWEEP_PAUSE_EN is defined); slave drives count[WIDTH], dir, busy,
//           done, err.
// Macro   : SWEEP_PAUSE_EN adds the pause request line.
interface sweep_ctrl_if #(
   parameter int WIDTH = sweep_pkg::SWEEP_WIDTH_DEF
) ();

   logic             start;
   logic             stop;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
`ifdef SWEEP_PAUSE_EN
   logic             pause;
`endif
   logic [WIDTH-1:0] count;
   logic             dir;
   logic             busy;
   logic             done;
   logic             err;

`ifdef SWEEP_PAUSE_EN
   modport master (
      output start, stop, lo, hi, pause,
      input  count, dir, busy, done, err
   );
   modport slave (
      input  start, stop, lo, hi, pause,
      output count, dir, busy, done, err
   );
`else
   modport master (
      output start, stop, lo, hi,
      input  count, dir, busy, done, err
   );
   modport slave (
      input  start, stop, lo, hi,
      output count, dir, busy, done, err
   );
`endif

endinterface

// File: rtl/count_core.sv
// rtl/count_core.sv - loadable up/down counter primitive
//
// Purpose : WIDTH-bit counter that can be loaded or stepped by one in either
//           direction; steps wrap modulo 2**WIDTH.
// Ports   : clk   - clock, rising edge
//           nrst  - asynchronous active-low reset (count -> 0)
//           en    - step enable
//           dir   - 1 = +1, 0 = -1
//           load  - load din (wins over en)
//           din   - load value
//           count - registered counter value
module count_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = din;
      end else if (en) begin
         count_d = dir ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/sweep_ctrl.sv
// rtl/sweep_ctrl.sv - bounce-sweep sequencer driving a count_core counter
//
// Purpose : on start, loads the low bound and bounces the counter lo -> hi -> lo
//           NPASS times, dwelling one cycle at each bound, then pulses done.
//           stop aborts from any busy state; lo > hi is rejected with err.
// Ports   : clk  - clock, rising edge
//           nrst - asynchronous active-low reset
//           bus  - sweep_ctrl_if.slave: start, stop, lo, hi (, pause) in;
//                  count, dir, busy, done, err out (all registered)
// Params  : WIDTH (bound/counter width), NPASS (round trips, >=1),
//           PCW (pass counter width, NPASS < 2**PCW)
// Macro   : SWEEP_PAUSE_EN - pause input freezes UP/DOWN progress.
module sweep_ctrl
   import sweep_pkg::*;
#(
   parameter int WIDTH = SWEEP_WIDTH_DEF,
   parameter int NPASS = SWEEP_NPASS_DEF,
   parameter int PCW   = SWEEP_PCW_DEF
) (
   input  logic         clk,
   input  logic         nrst,
   sweep_ctrl_if.slave  bus
);

   localparam logic [PCW-1:0] NPASS_C = PCW'(NPASS);

   sweep_state_e     state_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] hi_q;
   logic [PCW-1:0]   pass_q;
   logic             dir_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;

   logic [WIDTH-1:0] count;
   logic             core_en;
   logic             core_dir;
   logic             core_load;
   logic             hold;
   logic             at_hi;
   logic             at_lo;
   logic             pass_last;

`ifdef SWEEP_PAUSE_EN
   // pause only matters in UP/DOWN; the state decode below ignores it elsewhere.
   assign hold = bus.pause;
`else
   assign hold = 1'b0;
`endif

   assign at_hi     = (count == hi_q);
   assign at_lo     = (count == lo_q);
   assign pass_last = ((pass_q + PCW'(1)) == NPASS_C);

   // Counter stepping is decoded from the current state so count moves on the
   // same edge as the state decision; stop suppresses every counter action,
   // which is what leaves count held on abort.
   always_comb begin
      core_load = 1'b0;
      core_en   = 1'b0;
      core_dir  = 1'b0;
      if (!bus.stop) begin
         case (state_q)
            ST_LOAD: core_load = 1'b1;
            ST_UP: begin
               if (!hold && !at_hi) begin
                  core_en  = 1'b1;
                  core_dir = 1'b1;
               end
            end
            ST_DOWN: begin
               if (!hold && !at_lo) begin
                  core_en = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= ST_IDLE;
         lo_q    <= '0;
         hi_q    <= '0;
         pass_q  <= '0;
         dir_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (bus.stop) begin
            // Also covers start+stop in IDLE: nothing is latched, no err.
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (bus.start) begin
                     if (bus.lo <= bus.hi) begin
                        lo_q    <= bus.lo;
                        hi_q    <= bus.hi;
                        pass_q  <= '0;
                        state_q <= ST_LOAD;
                        dir_q   <= 1'b1;
                        busy_q  <= 1'b1;
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
               end
               ST_LOAD: begin
                  state_q <= ST_UP;
               end
               ST_UP: begin
                  // Reaching hi costs one dwell cycle before the descent.
                  if (!hold && at_hi) begin
                     state_q <= ST_DOWN;
                     dir_q   <= 1'b0;
                  end
               end
               ST_DOWN: begin
                  if (!hold && at_lo) begin
                     pass_q <= pass_q + PCW'(1);
                     if (pass_last) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= ST_UP;
                        dir_q   <= 1'b1;
                     end
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  dir_q   <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   count_core #(
      .WIDTH (WIDTH)
   ) u_count_core (
      .clk   (clk),
      .nrst  (nrst),
      .en    (core_en),
      .dir   (core_dir),
      .load  (core_load),
      .din   (lo_q),
      .count (count)
   );

   assign bus.count = count;
   assign bus.dir   = dir_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.err   = err_q;

endmodule
